aes_round_sequencer: RTL and testbench

Sequences one 128-bit AES-128 block through 11 key-addition steps (round 0 plus rounds 1..10). Holds the state register and requests round keys from the key scheduler through a handshake. Drives an external combinational round-function block (SubBytes/ShiftRows/MixColumns or their inverses) and XORs its result with each key using an instantiated add_round_key. Sits between the SD data buffer (input and output handshakes) and the key-expansion unit.

---
 rtl/aes_pkg.sv | 15 +
 rtl/add_round_key.sv | 12 +
 rtl/aes_round_sequencer.sv | 154 +++++++++++++++
 tb/tb_aes_round_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and constants for the round sequencer slice.
package aes_pkg;

    localparam int AES_BLOCK_W       = 128;
    localparam int AES128_NUM_ROUNDS = 10;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE,
        KEY,
        OUT
    } seq_state_t;

endpackage

// File: rtl/add_round_key.sv
// AddRoundKey: XOR of a 128-bit block with a 128-bit round key.
module add_round_key
    import aes_pkg::*;
(
    input  aes_block_t data_in,
    input  aes_block_t key,
    output aes_block_t data_out
);

    assign data_out = data_in ^ key;

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: steps one block through rounds 0..NUM_ROUNDS,
// fetching each round key over a req/ack handshake and combining the
// external round-function result with the key via one add_round_key.
// Optional build macro: AES_KEY_TIMEOUT_EN adds a key_ack watchdog that
// abandons the block and raises err after KEY_TIMEOUT idle KEY cycles.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS  = AES128_NUM_ROUNDS,
    parameter int KEY_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [127:0]     data_in,
    output logic             busy,
    output logic             key_req,
    output logic [3:0]       key_round,
    input  logic             key_ack,
    input  logic [127:0]     key_in,
    output logic [127:0]     rf_state,
    output logic             rf_inverse,
    output logic             rf_last,
    input  logic [127:0]     rf_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     data_out,
    output logic             err
);

    localparam int              RW        = $clog2(NUM_ROUNDS + 1);
    localparam logic [RW-1:0]   LAST_RND  = RW'(NUM_ROUNDS);
    localparam logic [RW-1:0]   RND_ONE   = RW'(1);

    seq_state_t     r_fsm;
    aes_block_t     r_blk;
    logic [RW-1:0]  r_round;
    logic           r_inverse;
    logic           r_busy;
    logic           r_key_req;
    logic           r_out_valid;

    aes_block_t     w_ark_in;
    aes_block_t     w_ark_out;
    logic [RW-1:0]  w_key_idx;
    logic           w_last;

    // Round 0 whitens the raw input; later rounds key the round-function output.
    assign w_ark_in  = (r_round == '0) ? r_blk : rf_result;
    // Decryption walks the key schedule backwards (equivalent inverse cipher).
    assign w_key_idx = r_inverse ? (LAST_RND - r_round) : r_round;
    assign w_last    = (r_round == LAST_RND);

    add_round_key u_ark (
        .data_in  (w_ark_in),
        .key      (key_in),
        .data_out (w_ark_out)
    );

    assign busy       = r_busy;
    assign key_req    = r_key_req;
    assign key_round  = 4'(w_key_idx);
    assign rf_state   = r_blk;
    assign rf_inverse = r_inverse;
    assign rf_last    = w_last;
    assign out_valid  = r_out_valid;
    assign data_out   = r_blk;

`ifdef AES_KEY_TIMEOUT_EN
    localparam int             TW      = $clog2(KEY_TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_MAX = TW'(KEY_TIMEOUT - 1);
    localparam logic [TW-1:0]  TMO_ONE = TW'(1);

    logic [TW-1:0] r_tmo;
    logic          r_err;

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // Sequencer FSM: block/round registers and all registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_blk       <= '0;
            r_round     <= '0;
            r_inverse   <= 1'b0;
            r_busy      <= 1'b0;
            r_key_req   <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef AES_KEY_TIMEOUT_EN
            r_tmo       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (start) begin
                        r_blk     <= data_in;
                        r_inverse <= mode;
                        r_round   <= '0;
                        r_busy    <= 1'b1;
                        r_key_req <= 1'b1;
                        r_fsm     <= KEY;
`ifdef AES_KEY_TIMEOUT_EN
                        r_tmo     <= '0;
                        r_err     <= 1'b0;
`endif
                    end
                end
                KEY: begin
                    if (key_ack) begin
                        r_blk <= w_ark_out;
`ifdef AES_KEY_TIMEOUT_EN
                        r_tmo <= '0;
`endif
                        if (w_last) begin
                            r_key_req   <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_fsm       <= OUT;
                        end else begin
                            r_round <= r_round + RND_ONE;
                        end
                    end
`ifdef AES_KEY_TIMEOUT_EN
                    else if (r_tmo == TMO_MAX) begin
                        // Key scheduler went silent: drop the block, flag it.
                        r_tmo     <= '0;
                        r_err     <= 1'b1;
                        r_key_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_fsm     <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_ONE;
                    end
`endif
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_fsm       <= IDLE;
                    end
                end
                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with an AES round-function model
// and a key-schedule model acting as the surrounding blocks.
module tb_aes_round_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [127:0] data_in;
    logic         busy;
    logic         key_req;
    logic [3:0]   key_round;
    logic         key_ack;
    logic [127:0] key_in;
    logic [127:0] rf_state;
    logic         rf_inverse;
    logic         rf_last;
    logic [127:0] rf_result;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         err;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K0ID = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ONES = {128{1'b1}};

    always #5 clk = ~clk;

    aes_round_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .data_in    (data_in),
        .busy       (busy),
        .key_req    (key_req),
        .key_round  (key_round),
        .key_ack    (key_ack),
        .key_in     (key_in),
        .rf_state   (rf_state),
        .rf_inverse (rf_inverse),
        .rf_last    (rf_last),
        .rf_result  (rf_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .err        (err)
    );

    // ---------------- AES model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gm(r, x);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] s);
        return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] mixb(input logic [127:0] s, input bit inv);
        logic [7:0]   co [4];
        logic [7:0]   a  [4];
        logic [7:0]   o;
        logic [127:0] r = '0;
        if (inv) begin co[0] = 8'h0e; co[1] = 8'h0b; co[2] = 8'h0d; co[3] = 8'h09; end
        else     begin co[0] = 8'h02; co[1] = 8'h03; co[2] = 8'h01; co[3] = 8'h01; end
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                o = 8'h00;
                for (int j = 0; j < 4; j++) o = o ^ gm(a[j], co[(j - rr + 4) % 4]);
                r[127-8*(4*c+rr) -: 8] = o;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] aes_rnd(input logic [127:0] s, input bit inv, input bit last);
        logic [7:0]   a [16];
        logic [127:0] b = '0;
        for (int i = 0; i < 16; i++)
            a[i] = inv ? isbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++)
                b[127-8*(rr+4*c) -: 8] = inv ? a[rr + 4*((c - rr + 4) % 4)]
                                             : a[rr + 4*((c + rr) % 4)];
        return last ? b : mixb(b, inv);
    endfunction

    // ---------------- environment ----------------
    logic [127:0] ks   [0:10];
    logic [127:0] ekey [0:10];
    bit           rf_real;
    int           ack_mode;   // 0: always, 1: every third cycle, 2: never
    int           phase;

    always_comb rf_result = rf_real ? aes_rnd(rf_state, rf_inverse, rf_last) : rf_state;

    assign key_in  = (key_round <= 4'd10) ? ks[key_round] : '0;
    assign key_ack = key_req && ((ack_mode == 0) || (ack_mode == 1 && phase == 2));

    always @(posedge clk) phase <= key_req ? ((phase == 2) ? 0 : phase + 1) : 0;

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ekey[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // 0: identity-test keys, 1: FIPS encrypt schedule, 2: FIPS decryption schedule
    task automatic load_keys(input int sel);
        for (int r = 0; r < 11; r++) begin
            case (sel)
                0:       ks[r] = (r == 0) ? K0ID : '0;
                1:       ks[r] = ekey[r];
                default: ks[r] = (r == 0 || r == 10) ? ekey[r] : mixb(ekey[r], 1'b1);
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit           md;
        logic [127:0] din;
        int           keyset;
        bit           real_rf;
        int           ackm;
        logic [127:0] exp_out;
        int           exp_cyc;
    } vec_t;

    vec_t vt [5];

    // One full block: start, monitor to out_valid, check, handshake.
    task automatic run_block(input vec_t v, input string tag);
        int           n = 0;
        int           kr [$];
        bit           prev_stall = 1'b0;
        logic [3:0]   prev_kr = '0;
        logic [127:0] prev_st = '0;
        load_keys(v.keyset);
        rf_real  = v.real_rf;
        ack_mode = v.ackm;
        @(negedge clk);
        start = 1'b1; mode = v.md; data_in = v.din;
        @(posedge clk);
        #1;
        start = 1'b0; mode = ~v.md; data_in = {$urandom, $urandom, $urandom, $urandom};
        while (n <= 200) begin
            @(negedge clk);
            if (out_valid) break;
            if (prev_stall) begin
                chk({tag, " stall_round"}, 128'(key_round), 128'(prev_kr));
                chk({tag, " stall_state"}, rf_state, prev_st);
            end
            if (key_ack) kr.push_back(int'(key_round));
            prev_stall = key_req && !key_ack;
            prev_kr    = key_round;
            prev_st    = rf_state;
            @(posedge clk);
            n++;
        end
        if (!out_valid) begin
            errors++;
            $display("FAIL %s timeout: out_valid never rose within %0d cycles", tag, n);
            return;
        end
        chk({tag, " data_out"}, data_out, v.exp_out);
        chk({tag, " out_cycle"}, 128'(n + 1), 128'(v.exp_cyc));
        chk({tag, " key_count"}, 128'(kr.size()), 128'd11);
        for (int i = 0; i < kr.size() && i < 11; i++)
            chk({tag, " key_round"}, 128'(kr[i]), 128'(v.md ? 10 - i : i));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, " idle_after"}, {126'd0, busy, out_valid}, '0);
    endtask

    initial begin
        int  n;
        bit  seen_valid;
        rst = 1'b1; start = 1'b0; mode = 1'b0; data_in = '0; out_ready = 1'b0;
        rf_real = 1'b0; ack_mode = 0;
        expand(FKEY);
        load_keys(0);

        vt[0] = '{1'b0, PT,  0, 1'b0, 0, ONES, 12};
        vt[1] = '{1'b0, PT,  1, 1'b1, 0, CT,   12};
        vt[2] = '{1'b1, CT,  2, 1'b1, 0, PT,   12};
        vt[3] = '{1'b0, PT,  0, 1'b0, 1, ONES, 34};
        vt[4] = '{1'b1, '0,  0, 1'b0, 0, K0ID, 12};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ctrl", {122'd0, busy, key_req, out_valid, err, rf_inverse, rf_last}, '0);
        chk("reset data_out", data_out, '0);
        chk("reset key_round", 128'(key_round), '0);
        rst = 1'b0;

        // FIPS-197 C.1 round key 10 sanity on the key-schedule model.
        chk("model ekey10", ekey[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        for (int i = 0; i < 5; i++) run_block(vt[i], $sformatf("vec%0d", i));

        // Backpressure with start pulses during KEY and OUT.
        load_keys(0); rf_real = 1'b0; ack_mode = 0;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; data_in = PT;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; mode = 1'b1; data_in = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("bp out_valid", 128'(out_valid), 128'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("bp hold_valid", 128'(out_valid), 128'd1);
            chk("bp hold_data", data_out, ONES);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp idle", {126'd0, busy, out_valid}, '0);
        @(negedge clk);
        chk("bp no_queue", {126'd0, busy, key_req}, '0);

        // Asynchronous reset in the middle of a block.
        load_keys(1); rf_real = 1'b1; ack_mode = 0;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; data_in = PT;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (key_round != 4'd5 && n < 100) begin @(negedge clk); n++; end
        chk("rst reached_r5", 128'(key_round), 128'd5);
        rst = 1'b1;
        #1;
        chk("rst async ctrl", {122'd0, busy, key_req, out_valid, err, rf_inverse, rf_last}, '0);
        chk("rst async data", data_out, '0);
        chk("rst async state", rf_state, '0);
        chk("rst async round", 128'(key_round), '0);
        @(negedge clk);
        rst = 1'b0;
        run_block(vt[1], "post_rst");

`ifdef AES_KEY_TIMEOUT_EN
        // Key scheduler never answers: watchdog drops the block.
        load_keys(0); rf_real = 1'b0; ack_mode = 2;
        seen_valid = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; data_in = PT;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (n <= 200) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
            if (!busy) break;
            @(posedge clk);
            n++;
        end
        chk("tmo cycles", 128'(n), 128'd64);
        chk("tmo err", 128'(err), 128'd1);
        chk("tmo no_valid", 128'(seen_valid), '0);
        repeat (3) @(negedge clk);
        chk("tmo err_sticky", 128'(err), 128'd1);
        run_block(vt[0], "after_tmo");
        chk("tmo err_cleared", 128'(err), '0);
`else
        seen_valid = 1'b0;
        chk("err tied", 128'(err), 128'(seen_valid));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
